// File: rtl/rs_cmd_debouncer.sv
// Set/reset request conditioner for the RS trigger: per-channel 2-FF sync and
// debounce, then a small FSM that issues mutually exclusive, spaced S/R pulses.

module rs_deb_chan #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic req_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter tracks consecutive cycles the synced level disagrees with deb_q.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        req_o = 1'b0;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d = '0;
            deb_d = ~deb_q;
            req_o = ~deb_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module rs_cmd_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 1,
    parameter int HOLDOFF         = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);
    localparam int TMAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, HOLD} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    btn_raw, req, pend_q, pend_d, pend_clr;
    logic          s_q, r_q, busy_q, conflict_q, conflict_d;

    // Channel 0 is set, channel 1 is reset.
    assign btn_raw = {btn_r, btn_s};

    rs_deb_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan [1:0] (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_raw),
        .req_o (req)
    );

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        pend_clr   = 2'b00;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (pend_q == 2'b11) begin
                    conflict_d = 1'b1;
                    pend_clr   = 2'b11;
                end else if (pend_q[0]) begin
                    state_d  = PULSE_S;
                    pend_clr = 2'b01;
                end else if (pend_q[1]) begin
                    state_d  = PULSE_R;
                    pend_clr = 2'b10;
                end
            end
            PULSE_S, PULSE_R: begin
                if (tmr_q == TW'(PULSE_LEN - 1)) begin
                    tmr_d   = '0;
                    state_d = (HOLDOFF == 0) ? IDLE : HOLD;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            HOLD: begin
                if (tmr_q == TW'(HOLDOFF - 1)) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
        // A fresh request wins over a same-cycle consume so it is never dropped.
        pend_d = (pend_q & ~pend_clr) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            pend_q     <= 2'b00;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pend_q     <= pend_d;
            s_q        <= (state_d == PULSE_S);
            r_q        <= (state_d == PULSE_R);
            busy_q     <= (state_d != IDLE);
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
endmodule

// File: tb/tb_rs_cmd_debouncer.sv
// Scoreboard bench for rs_cmd_debouncer: a cycle-stepped behavioural model
// predicts {s,r,busy,conflict} per edge; a monitor compares after each edge.

module tb_rs_cmd_debouncer;
    localparam int D  = 4;
    localparam int PL = 1;
    localparam int HO = 2;

    logic clk = 1'b0;
    logic rst, btn_s, btn_r;
    logic s, r, busy, conflict;

    always #5 clk = ~clk;

    rs_cmd_debouncer #(.DEBOUNCE_CYCLES(D), .PULSE_LEN(PL), .HOLDOFF(HO)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_s    (btn_s),
        .btn_r    (btn_r),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .conflict (conflict)
    );

    logic [3:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Model state: last two samples per button, window of last D synced
    // values, debounced level, pending flag, and remaining pulse/busy cycles.
    bit m_s1[2], m_s2[2], m_deb[2], m_pend[2];
    bit m_win[2][$];
    int m_busy_left = 0, m_pulse_left = 0, m_pulse_ch = 0;

    task automatic model_step(input bit rs, input bit bs, input bit br);
        bit b[2];
        bit req[2];
        bit conf;
        bit v, all_diff;
        b[0] = bs; b[1] = br;
        if (rs) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_pend[c] = 0;
                m_win[c].delete();
            end
            m_busy_left = 0; m_pulse_left = 0;
            exp_q.push_back(4'b0000);
            return;
        end
        for (int c = 0; c < 2; c++) begin
            v = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = b[c];
            m_win[c].push_back(v);
            if (m_win[c].size() > D) void'(m_win[c].pop_front());
            req[c] = 0;
            if (m_win[c].size() == D) begin
                all_diff = 1;
                foreach (m_win[c][i]) if (m_win[c][i] == m_deb[c]) all_diff = 0;
                if (all_diff) begin
                    m_deb[c] = ~m_deb[c];
                    req[c]   = m_deb[c];
                end
            end
        end
        conf = 0;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_pulse_left > 0) m_pulse_left--;
        end else if (m_pend[0] && m_pend[1]) begin
            conf = 1; m_pend[0] = 0; m_pend[1] = 0;
        end else if (m_pend[0] || m_pend[1]) begin
            m_pulse_ch   = m_pend[0] ? 0 : 1;
            m_pend[m_pulse_ch] = 0;
            m_pulse_left = PL;
            m_busy_left  = PL + HO;
        end
        for (int c = 0; c < 2; c++) if (req[c]) m_pend[c] = 1;
        exp_q.push_back({(m_pulse_left > 0) && (m_pulse_ch == 0),
                         (m_pulse_left > 0) && (m_pulse_ch == 1),
                         (m_busy_left > 0), conf});
    endtask

    task automatic cyc(input bit rs, input bit bs, input bit br);
        rst = rs; btn_s = bs; btn_r = br;
        model_step(rs, bs, br);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input bit rs, input bit bs, input bit br);
        for (int i = 0; i < n; i++) cyc(rs, bs, br);
    endtask

    // Monitor: every edge with a pending prediction is compared.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({s, r, busy, conflict} !== e) begin
                    errors++;
                    $display("FAIL outputs edge %0d: {s,r,busy,conflict} got %b expected %b",
                             edge_no, {s, r, busy, conflict}, e);
                end
                checks++;
                if (s === 1'b1 && r === 1'b1) begin
                    errors++;
                    $display("FAIL exclusive edge %0d: s=%b r=%b, expected not both 1", edge_no, s, r);
                end
            end
        end
    end

    initial begin
        bit bs, br;
        rst = 1'b1; btn_s = 1'b0; btn_r = 1'b0;
        // Reset held with both buttons high; only set stays high afterwards.
        hold(3, 1, 1, 1);
        hold(12, 0, 1, 0);
        hold(14, 0, 0, 0);
        // Clean set.
        hold(10, 0, 1, 0);
        hold(14, 0, 0, 0);
        // Glitch on reset line, then a just-long-enough press.
        hold(3, 0, 0, 1);
        hold(12, 0, 0, 0);
        hold(4, 0, 0, 1);
        hold(14, 0, 0, 0);
        // Simultaneous requests.
        hold(10, 0, 1, 1);
        hold(14, 0, 0, 0);
        // Back-to-back: reset request two cycles behind set.
        hold(2, 0, 1, 0);
        hold(14, 0, 1, 1);
        hold(14, 0, 0, 0);
        // Reset on the edge that would start the set pulse.
        hold(2, 0, 1, 0);
        hold(4, 0, 1, 1);
        cyc(1, 1, 1);
        hold(16, 0, 0, 0);
        // Randomised bouncy traffic with occasional resets.
        bs = 0; br = 0;
        for (int blk = 0; blk < 75; blk++) begin
            int p = ($urandom_range(0, 1) == 0) ? 3 : 30;
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, p - 1) == 0) bs = ~bs;
                if ($urandom_range(0, p - 1) == 0) br = ~br;
                cyc(($urandom_range(0, 299) == 0), bs, br);
            end
        end
        hold(16, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_cmd_debouncer.md
Name: rs_cmd_debouncer

Overview:
- Upstream conditioning stage for the RS trigger.
- Takes two raw, possibly bouncy, asynchronous set/reset request lines and synchronises and debounces them.
- Converts each debounced rising edge into a clean, clock-aligned S or R pulse of fixed length.
- Guarantees the downstream trigger never sees S and R asserted together.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new level must hold before the debounced state changes (≥2).
- PULSE_LEN, 1: cycles that s or r stays high per accepted request (≥1).
- HOLDOFF, 2: idle cycles forced after each pulse before the next pulse may start (≥0).

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- btn_s  input  1  raw asynchronous set request
- btn_r  input  1  raw asynchronous reset request
- s  output  1  registered set pulse to the RS trigger
- r  output  1  registered reset pulse to the RS trigger
- busy  output  1  high whenever the FSM is not in IDLE
- conflict  output  1  one-cycle registered flag: simultaneous S and R requests discarded

Behaviour:
- Reset: on any edge with rst=1, the following are all cleared to 0: s, r, busy, conflict, both 2-FF synchronisers, both debounced states, both counters, both pending flags. FSM goes to IDLE. A reset mid-pulse or mid-holdoff drops s/r at that same edge. rst overrides every other event.
- Synchroniser: each btn_* passes through 2 flops giving sync_*.
- Debounce, per channel:
  - If sync_x == deb_x, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync_x still differs, deb_x toggles at that edge and the counter clears.
  - A level that reverts before then leaves deb_x unchanged and clears the counter.
- Request: req_x is asserted for the cycle in which deb_x toggles 0→1. A 1→0 toggle generates nothing.
- Pending: req_x sets pend_x. pend_x is cleared when consumed by IDLE or on conflict. Each channel holds at most one pending request; extra requests merge.
- FSM states: IDLE, PULSE_S, PULSE_R, HOLD.
  - IDLE, pend_s=1 and pend_r=1: stay in IDLE, conflict=1 next cycle, clear both pending flags.
  - IDLE, only pend_s=1: go to PULSE_S, clear pend_s.
  - IDLE, only pend_r=1: go to PULSE_R, clear pend_r.
  - PULSE_S / PULSE_R: s (or r) is 1 for exactly PULSE_LEN cycles, then go to HOLD. If HOLDOFF=0, go straight to IDLE.
  - HOLD: stay HOLDOFF cycles, then go to IDLE.
  - Requests arriving in PULSE_*/HOLD are held pending and serviced on return to IDLE.
- Outputs:
  - s and r are decoded registered from state, never combinational from inputs.
  - s&r==1 is impossible in every cycle.
  - busy = (state != IDLE).
  - conflict is high for exactly one cycle per discarded pair.
- Latency, defaults:
  - btn_s is first sampled high at edge k.
  - deb_s toggles at edge k+1+DEBOUNCE_CYCLES (k+5).
  - s=1 from edge k+2+DEBOUNCE_CYCLES (k+6) for PULSE_LEN cycles.
  - Minimum spacing between pulse starts is PULSE_LEN+HOLDOFF+1 cycles (4).
- Counters are sized with $clog2 of their parameter. No wrap-around is permitted: counters clear at their terminal values.

Test Plan:
- Reset behaviour: hold rst=1 for 3 cycles with btn_s=btn_r=1. Required: s=r=busy=conflict=0 throughout, and the first s pulse appears only 6 cycles after rst drops.
- Clean set: btn_s goes 0→1 and holds (defaults). Required: s=1 for exactly 1 cycle at edge k+6, busy=1 for 3 cycles (pulse plus 2 holdoff), r stays 0.
- Glitch rejection: btn_r high for 3 cycles, then low. Required: deb_r never toggles, r stays 0, busy stays 0. A 4-cycle-stable high must produce one r pulse.
- Simultaneous requests: btn_s and btn_r rise on the same edge. Required: no s or r pulse, conflict=1 for exactly one cycle at edge k+6, busy=0.
- Back-to-back: btn_r rises 2 cycles after btn_s. Required: s pulse at k+6, r pulse deferred to k+10 (after holdoff), never overlapping, 1 cycle each.
- Reset mid-operation: assert rst during the PULSE_S cycle. Required: s=0 at that edge, the pending r request is lost, and no pulse occurs until a new debounced edge.
